// File: rtl/regfile_dbg_access.sv
// Debugger access port to the core register file: halts the core, performs a
// single read or write through the writeback mux and returns one response.
module regfile_dbg_access #(
    parameter int REG_WIDTH    = 32,
    parameter int NUM_REGS     = 32,
    parameter bit R0_IS_ZERO   = 1'b1,
    parameter int HALT_TIMEOUT = 255,
    localparam int AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                 Clk_i,
    input  logic                 Rst_ni,

    input  logic                 Cmd_Valid_i,
    output logic                 Cmd_Ready_o,
    input  logic                 Cmd_Write_i,
    input  logic [AW-1:0]        Cmd_Addr_i,
    input  logic [REG_WIDTH-1:0] Cmd_Data_i,

    output logic                 Rsp_Valid_o,
    input  logic                 Rsp_Ready_i,
    output logic [REG_WIDTH-1:0] Rsp_Data_o,
    output logic                 Rsp_Err_o,

    output logic                 Halt_Req_o,
    input  logic                 Halted_i,

    input  logic                 Core_We_i,

    output logic [AW-1:0]        Rf_Sel_o,
    input  logic [REG_WIDTH-1:0] Rf_Data_i,

    output logic                 Rf_We_o,
    output logic [AW-1:0]        Rf_Rd_Sel_o,
    output logic [REG_WIDTH-1:0] Rf_Data_o
);

    localparam int            CNT_W      = (HALT_TIMEOUT > 2) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [AW:0]   NUM_REGS_W = (AW+1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        ACCESS    = 2'd2,
        RESP      = 2'd3
    } state_e;

    state_e                 state_q;
    state_e                 state_d;

    logic                   wr_q;
    logic [AW-1:0]          addr_q;
    logic [REG_WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [REG_WIDTH-1:0]   rsp_data_q;
    logic                   rsp_err_q;

    logic                   cmd_fire;
    logic                   timeout_hit;
    logic                   addr_ok;
    logic                   zero_reg;
    logic                   wr_target;
    logic                   wr_blocked;

    // Addresses past the last register only exist when NUM_REGS is not a power of two.
    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < NUM_REGS_W);
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return R0_IS_ZERO && (a == '0);
    endfunction

    assign cmd_fire    = Cmd_Valid_i && (state_q == IDLE);
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign addr_ok     = addr_in_range(addr_q);
    assign zero_reg    = is_zero_reg(addr_q);
    assign wr_target   = wr_q && addr_ok && !zero_reg;
    // The core writeback owns the write port; the debug write waits it out.
    assign wr_blocked  = wr_target && Core_We_i;

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) state_d = HALT_WAIT;
            end
            HALT_WAIT: begin
                if (Halted_i)         state_d = ACCESS;
                else if (timeout_hit) state_d = RESP;
            end
            ACCESS: begin
                if (!wr_blocked) state_d = RESP;
            end
            RESP: begin
                if (Rsp_Ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Cmd_Ready_o = 1'b0;
        Halt_Req_o  = 1'b0;
        Rsp_Valid_o = 1'b0;
        Rf_We_o     = 1'b0;
        unique case (state_q)
            IDLE:      Cmd_Ready_o = 1'b1;
            HALT_WAIT: Halt_Req_o  = 1'b1;
            ACCESS: begin
                Halt_Req_o = 1'b1;
                Rf_We_o    = wr_target && !Core_We_i;
            end
            RESP: begin
                Halt_Req_o  = 1'b1;
                Rsp_Valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch, halt-wait counter and response registers.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        wr_q       <= Cmd_Write_i;
                        addr_q     <= Cmd_Addr_i;
                        data_q     <= Cmd_Data_i;
                        cnt_q      <= '0;
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                    end
                end
                HALT_WAIT: begin
                    if (!Halted_i) begin
                        if (timeout_hit) rsp_err_q <= 1'b1;
                        else             cnt_q     <= cnt_q + CNT_W'(1);
                    end
                end
                ACCESS: begin
                    if (!addr_ok)   rsp_err_q  <= 1'b1;
                    else if (!wr_q) rsp_data_q <= Rf_Data_i;
                end
                default: ;
            endcase
        end
    end

    assign Rsp_Data_o  = rsp_data_q;
    assign Rsp_Err_o   = rsp_err_q;
    assign Rf_Sel_o    = addr_q;
    assign Rf_Rd_Sel_o = addr_q;
    assign Rf_Data_o   = data_q;

endmodule
